// File: rtl/alu_serial_seq_if.sv
// ---------------------------------------------------------------------------
// alu_serial_seq_if
//   Request/response bundle between a requester and the bit-serial ALU
//   sequencer.
//
//   Signals (directions seen from the sequencer, i.e. the slave modport):
//     start        in   request; accepted only while the sequencer is idle
//     src1, src2   in   WIDTH-bit operands, latched on accept
//     ALU_control  in   4-bit opcode, latched on accept
//     busy         out  high while bits are being processed
//     done         out  one-cycle pulse when result/flags are valid
//     result       out  assembled WIDTH-bit result, held until next accept
//     zero         out  result == 0
//     cout         out  carry out of the MSB (ADD/SUB only)
//     overflow     out  signed overflow (ADD/SUB only)
// ---------------------------------------------------------------------------
interface alu_serial_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [3:0]       ALU_control;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;

  modport master (
    output start, src1, src2, ALU_control,
    input  busy, done, result, zero, cout, overflow
  );

  modport slave (
    input  start, src1, src2, ALU_control,
    output busy, done, result, zero, cout, overflow
  );
endinterface

// File: rtl/alu_serial_seq.sv
// ---------------------------------------------------------------------------
// alu_serial_seq
//   Bit-serial ALU sequencer. Latches one operation, then drives an external
//   1-bit ALU slice once per cycle, LSB first, collecting the slice result and
//   carry. After the last bit it publishes the assembled result together with
//   zero/cout/overflow flags and pulses done.
//
//   Ports:
//     clk              in   rising-edge clock
//     rst_n            in   asynchronous active-low reset (aborts any op)
//     bus              --   request/response bundle (slave modport)
//     slice_src1/2     out  operand bits for the current slice position
//     slice_less       out  tied low
//     slice_A_invert   out  slice operand A inversion
//     slice_B_invert   out  slice operand B inversion
//     slice_cin        out  carry into the current bit
//     slice_operation  out  slice function select
//     slice_result     in   slice output bit (combinational)
//     slice_cout       in   slice carry out
//     slice_set        in   slice sum bit (used for SLT on the MSB)
// ---------------------------------------------------------------------------
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_serial_seq_if.slave       bus,
  output logic                  slice_src1,
  output logic                  slice_src2,
  output logic                  slice_less,
  output logic                  slice_A_invert,
  output logic                  slice_B_invert,
  output logic                  slice_cin,
  output logic [1:0]            slice_operation,
  input  logic                  slice_result,
  input  logic                  slice_cout,
  input  logic                  slice_set
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  typedef struct packed {
    logic       a_inv;
    logic       b_inv;
    logic [1:0] operation;
    logic       cin;
    logic       arith;
    logic       slt;
    logic       valid;
  } ctrl_t;

  // Opcode to slice controls. Unknown codes fall through to an AND drive
  // with valid=0 so the final result is forced to zero.
  function automatic ctrl_t decode(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      4'b0000: c.valid = 1'b1;
      4'b0001: begin c.operation = 2'b01; c.valid = 1'b1; end
      4'b0010: begin c.operation = 2'b10; c.arith = 1'b1; c.valid = 1'b1; end
      4'b0110: begin
        c.b_inv = 1'b1; c.operation = 2'b10; c.cin = 1'b1;
        c.arith = 1'b1; c.valid = 1'b1;
      end
      4'b0111: begin
        c.b_inv = 1'b1; c.operation = 2'b10; c.cin = 1'b1;
        c.slt = 1'b1; c.valid = 1'b1;
      end
      4'b1100: begin c.a_inv = 1'b1; c.b_inv = 1'b1; c.valid = 1'b1; end
      4'b1101: begin
        c.a_inv = 1'b1; c.b_inv = 1'b1; c.operation = 2'b01; c.valid = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       op_reg;
  logic             carry;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  ctrl_t            ctrl;
  logic             in_run;
  logic [WIDTH-1:0] final_bits;
  logic             msb_ovf;
  logic [WIDTH-1:0] next_result;

  assign ctrl   = decode(op_reg);
  assign in_run = (state == RUN);

  // Slice drives are decoded straight from registered state so that reset
  // silences them immediately. Bit 0 takes the opcode's initial carry.
  assign slice_src1      = in_run & a_reg[cnt];
  assign slice_src2      = in_run & b_reg[cnt];
  assign slice_less      = 1'b0;
  assign slice_A_invert  = in_run & ctrl.a_inv;
  assign slice_B_invert  = in_run & ctrl.b_inv;
  assign slice_cin       = in_run & ((cnt == '0) ? ctrl.cin : carry);
  assign slice_operation = in_run ? ctrl.operation : 2'b00;

  // Value to publish on the last bit edge. acc holds bits 0..WIDTH-2 and
  // the MSB comes live from the slice; carry holds the carry into the MSB.
  always_comb begin
    final_bits  = {slice_result, acc};
    msb_ovf     = carry ^ slice_cout;
    next_result = final_bits;
    if (!ctrl.valid) begin
      next_result = '0;
    end else if (ctrl.slt) begin
      next_result    = '0;
      next_result[0] = slice_set ^ msb_ovf;
    end
  end

  // Sequencer FSM. Flags and done are registered on the edge that captures
  // the MSB so they are valid during the single FINISH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= '0;
      carry    <= 1'b0;
      acc      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg  <= bus.src1;
            b_reg  <= bus.src2;
            op_reg <= bus.ALU_control;
            carry  <= decode(bus.ALU_control).cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc   <= {slice_result, acc[WIDTH-2:1]};
          carry <= slice_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            result_q <= next_result;
            zero_q   <= (next_result == '0);
            cout_q   <= ctrl.arith & slice_cout;
            ovf_q    <= ctrl.arith & msb_ovf;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= FINISH;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial 32-bit ALU sequencer on the initiator side of the 1-bit ALU slice interface.
- Latches a 32-bit operation, then drives one external 1-bit slice per cycle, LSB first, and collects its result/cout/set.
- Rebuilds the 32-bit result with zero/cout/overflow flags.
- Gives a low-area alternative to the 32-slice ripple ALU with a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width; counter sized to clog2(WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only in IDLE.
- src1  input  WIDTH  operand A, latched on accept.
- src2  input  WIDTH  operand B, latched on accept.
- ALU_control  input  4  opcode, latched on accept.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when results are valid.
- result  output  WIDTH  assembled result, held until next accept.
- zero  output  1  result==0.
- cout  output  1  carry out of MSB (ADD/SUB only).
- overflow  output  1  signed overflow (ADD/SUB only).
- slice_src1  output  1  to slice src1.
- slice_src2  output  1  to slice src2.
- slice_less  output  1  to slice less; always 0.
- slice_A_invert  output  1  to slice.
- slice_B_invert  output  1  to slice.
- slice_cin  output  1  to slice.
- slice_operation  output  2  to slice.
- slice_result  input  1  from slice, combinational.
- slice_cout  input  1  from slice.
- slice_set  input  1  from slice (sum bit).

Behaviour:
- Reset: all outputs 0 (result, zero, cout, overflow, busy, done, all slice_* drives); FSM goes to IDLE; bit counter 0. Reset is asynchronous and abortive at any point: no done pulse is emitted for an aborted operation.
- States:
  - IDLE: start=1 latches operands/opcode, loads carry register with the initial cin, clears counter, goes to RUN.
  - RUN: one bit per cycle. Goes to FINISH when the counter reaches WIDTH-1.
  - FINISH: sets flags, pulses done, returns to IDLE.
- Opcode decode (A_invert, B_invert, operation, initial cin):
  - 0000 AND → 0,0,00,0
  - 0001 OR → 0,0,01,0
  - 0010 ADD → 0,0,10,0
  - 0110 SUB → 0,1,10,1
  - 0111 SLT → 0,1,10,1
  - 1100 NOR → 1,1,00,0
  - 1101 NAND → 1,1,01,0
  - Any other code: slices are driven as AND; final result forced 0, cout 0, overflow 0.
- RUN cycle k (k=0..WIDTH-1):
  - slice_src1=A[k], slice_src2=B[k].
  - slice_cin = initial cin when k=0, else the registered slice_cout from bit k-1.
  - On the clock edge, slice_result is captured into result bit k and slice_cout into the carry register.
  - At k=WIDTH-1, also register carry-in-to-MSB, slice_cout and slice_set.
- FINISH:
  - ADD/SUB: cout = MSB carry-out; overflow = MSB carry-in XOR MSB carry-out.
  - SLT: result = {0…0, slice_set_MSB XOR overflow_MSB}; cout and overflow reported 0.
  - Logic ops: cout=0, overflow=0.
  - zero = (final result == 0), computed on the final value.
- Latency: start sampled at edge N → busy high for cycles N+1..N+WIDTH → done high for the single cycle N+WIDTH+1, with result/flags valid from that cycle.
- Holding: result and flags hold until the next accepted start and are not cleared at accept. busy is 0 in IDLE and FINISH.
- start while busy or in FINISH is ignored (no queueing). start held high after done starts a new operation on the next IDLE cycle.
- slice_* drives are 0 in IDLE and FINISH.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, cout 0, zero 0; done exactly 33 cycles after start edge, busy high for 32.
- SUB 5 − 5 → result 0, zero 1, cout 1, overflow 0.
- SLT 0xFFFFFFFF vs 0x00000001 → result 1. SLT 0x7FFFFFFF vs 0x80000000 → result 0 (overflow-corrected); both with cout=overflow=0.
- NOR 0 with 0 → 0xFFFFFFFF. NAND 0xFFFFFFFF with 0xFFFFFFFF → 0. OR 0xF0F0F0F0 with 0x0F0F0F0F → 0xFFFFFFFF. Unsupported code 1111 → result 0, zero 1.
- Second start pulsed at cycle 10 of an ADD → ignored; first result correct; no extra done.
- rst_n asserted at bit 16 of a SUB → busy, done, result and slice_* all 0 immediately; after release, a new ADD 3+4 → 7.
